// File: rtl/bola_fisica.sv
// bola_fisica: ball engine for the rat_race court (movement, bounces, goals, score, serve sequencing).
// Optional BOLA_ACELERA_EN: every 4th paddle hit raises the base ball speed up to 3.
module bola_fisica #(
  parameter int TELA_W     = 640,
  parameter int TELA_H     = 480,
  parameter int BOLA_TAM   = 10,
  parameter int BARRA_LARG = 20,
  parameter int BARRA_ALT  = 60,
  parameter int TICK_DIV   = 250000,
  parameter int SAQUE_DLY  = 100,
  parameter int MAX_PONTOS = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_barra_esq,
  input  logic [9:0] y_barra_esq,
  input  logic [9:0] x_barra_dir,
  input  logic [9:0] y_barra_dir,
  input  logic       porradao_esq,
  input  logic       porradao_dir,
  input  logic       saque,
  output logic [9:0] x_bola,
  output logic [9:0] y_bola,
  output logic       ponto_esq,
  output logic       ponto_dir,
  output logic [3:0] placar_esq,
  output logic [3:0] placar_dir,
  output logic [1:0] estado
);
  typedef enum logic [1:0] {ESPERA, SAQUE, JOGANDO, FIM} estado_t;
  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = (SAQUE_DLY < 2) ? 1 : $clog2(SAQUE_DLY + 1);
  localparam logic [9:0] XC = 10'((TELA_W - BOLA_TAM) / 2);
  localparam logic [9:0] YC = 10'((TELA_H - BOLA_TAM) / 2);
  localparam logic [11:0] W  = 12'(TELA_W);
  localparam logic [11:0] H  = 12'(TELA_H);
  localparam logic [11:0] BT = 12'(BOLA_TAM);
  localparam logic [11:0] BL = 12'(BARRA_LARG);
  localparam logic [11:0] BA = 12'(BARRA_ALT);
  localparam logic signed [12:0] XMAX = 13'(TELA_W - BOLA_TAM);
  estado_t est_q, est_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sdly_q, sdly_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [2:0] vx_mag_q, vx_mag_d, hit_mag;
  logic pe_q, pe_d, pd_q, pd_d;
  logic [3:0] se_q, se_d, sd_q, sd_d;
  logic [11:0] xb, yb, xe, ye, xd, yd, mag12;
  logic tick, hit_l, hit_r, gol_e, gol_d, smash;
  logic signed [12:0] nx;
  assign tick  = cnt_q == CW'(TICK_DIV - 1);
  assign xb    = {2'b0, x_q};
  assign yb    = {2'b0, y_q};
  assign xe    = {2'b0, x_barra_esq};
  assign ye    = {2'b0, y_barra_esq};
  assign xd    = {2'b0, x_barra_dir};
  assign yd    = {2'b0, y_barra_dir};
  assign mag12 = {9'b0, vx_mag_q};
  assign hit_l = vx_neg_q && xb <= xe + BL && xb + BT >= xe && yb + BT > ye && yb < ye + BA;
  assign hit_r = !vx_neg_q && xb + BT >= xd && xb <= xd + BL && yb + BT > yd && yb < yd + BA;
  assign gol_d = vx_neg_q && !hit_l && xb < mag12;
  assign gol_e = !vx_neg_q && !hit_r && xb + BT + mag12 > W;
  assign smash = hit_l ? porradao_esq : porradao_dir;
`ifdef BOLA_ACELERA_EN
  logic [1:0] base_q, base_d, hits_q, hits_d, base_n;
  // hits_q==3 means the hit being processed is the 4th one
  assign base_n  = (hits_q == 2'd3 && base_q != 2'd3) ? base_q + 2'd1 : base_q;
  assign hit_mag = {1'b0, base_n} + {2'b0, smash};
`else
  assign hit_mag = smash ? 3'd2 : 3'd1;
`endif
  always_comb begin
    est_d    = est_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    sdly_d   = sdly_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_neg_d = vx_neg_q;
    vx_mag_d = vx_mag_q;
    vy_neg_d = vy_neg_q;
    pe_d     = 1'b0;
    pd_d     = 1'b0;
    se_d     = se_q;
    sd_d     = sd_q;
    nx       = '0;
`ifdef BOLA_ACELERA_EN
    base_d   = base_q;
    hits_d   = hits_q;
`endif
    case (est_q)
      ESPERA: begin
        x_d = XC;
        y_d = YC;
        if (saque) begin
          est_d  = SAQUE;
          cnt_d  = '0;
          sdly_d = '0;
        end
      end
      SAQUE: if (tick) begin
        sdly_d = sdly_q + 1'b1;
        if (sdly_q == SW'(SAQUE_DLY - 1)) begin
          est_d = JOGANDO;
          cnt_d = '0;
        end
      end
      JOGANDO: if (tick) begin
        if (hit_l || hit_r) begin
          vx_neg_d = hit_r;
          vx_mag_d = hit_mag;
`ifdef BOLA_ACELERA_EN
          base_d   = base_n;
          hits_d   = hits_q + 2'd1;
`endif
        end
        if (gol_e || gol_d) begin
          pe_d     = gol_e;
          pd_d     = gol_d;
          se_d     = se_q + {3'b0, gol_e};
          sd_d     = sd_q + {3'b0, gol_d};
          vx_neg_d = gol_d;
          vx_mag_d = 3'd1;
          x_d      = XC;
          y_d      = YC;
          est_d    = (se_d == 4'(MAX_PONTOS) || sd_d == 4'(MAX_PONTOS)) ? FIM : ESPERA;
`ifdef BOLA_ACELERA_EN
          base_d   = 2'd1;
          hits_d   = 2'd0;
`endif
        end else begin
          vy_neg_d = vy_neg_q ? yb > 12'd1 : yb + BT + 12'd1 >= H;
          y_d      = vy_neg_d ? y_q - 10'd1 : y_q + 10'd1;
          nx       = $signed({3'b0, x_q}) + (vx_neg_d ? -$signed({10'b0, vx_mag_d}) : $signed({10'b0, vx_mag_d}));
          x_d      = nx[12] ? '0 : (nx > XMAX) ? 10'(XMAX) : nx[9:0];
        end
      end
      default: begin
        x_d = XC;
        y_d = YC;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      est_q    <= ESPERA;
      cnt_q    <= '0;
      sdly_q   <= '0;
      x_q      <= XC;
      y_q      <= YC;
      vx_neg_q <= 1'b0;
      vx_mag_q <= 3'd1;
      vy_neg_q <= 1'b0;
      pe_q     <= 1'b0;
      pd_q     <= 1'b0;
      se_q     <= '0;
      sd_q     <= '0;
`ifdef BOLA_ACELERA_EN
      base_q   <= 2'd1;
      hits_q   <= 2'd0;
`endif
    end else begin
      est_q    <= est_d;
      cnt_q    <= cnt_d;
      sdly_q   <= sdly_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_neg_q <= vx_neg_d;
      vx_mag_q <= vx_mag_d;
      vy_neg_q <= vy_neg_d;
      pe_q     <= pe_d;
      pd_q     <= pd_d;
      se_q     <= se_d;
      sd_q     <= sd_d;
`ifdef BOLA_ACELERA_EN
      base_q   <= base_d;
      hits_q   <= hits_d;
`endif
    end
  end
  assign x_bola     = x_q;
  assign y_bola     = y_q;
  assign ponto_esq  = pe_q;
  assign ponto_dir  = pd_q;
  assign placar_esq = se_q;
  assign placar_dir = sd_q;
  assign estado     = est_q;
endmodule

// File: tb/tb_bola_fisica.sv
// tb_bola_fisica: randomized play of bola_fisica against a cycle-level integer model of the court rules.
module tb_bola_fisica;
  localparam int TD = 4, SD = 2;
  logic clk = 1'b0, reset = 1'b1, saque = 1'b0, porradao_esq = 1'b0, porradao_dir = 1'b0;
  logic [9:0] x_barra_esq = 10'd20, y_barra_esq = 10'd1000, x_barra_dir = 10'd600, y_barra_dir = 10'd1000;
  logic [9:0] x_bola, y_bola;
  logic ponto_esq, ponto_dir;
  logic [3:0] placar_esq, placar_dir;
  logic [1:0] estado;
  int n_chk = 0, n_pass = 0;
  int m_x, m_y, m_vx, m_vy, m_se, m_sd, m_est, m_cnt, m_sdly;
  bit m_pe, m_pd;
  always #5 clk = ~clk;
  bola_fisica #(.TICK_DIV(TD), .SAQUE_DLY(SD)) dut (
    .clk(clk), .reset(reset),
    .x_barra_esq(x_barra_esq), .y_barra_esq(y_barra_esq),
    .x_barra_dir(x_barra_dir), .y_barra_dir(y_barra_dir),
    .porradao_esq(porradao_esq), .porradao_dir(porradao_dir), .saque(saque),
    .x_bola(x_bola), .y_bola(y_bola), .ponto_esq(ponto_esq), .ponto_dir(ponto_dir),
    .placar_esq(placar_esq), .placar_dir(placar_dir), .estado(estado)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  task automatic model_step();
    bit tk, hl, hr, ge, gd;
    int mag, xe, ye, xd, yd;
    if (reset) begin
      m_x = 315; m_y = 235; m_vx = 1; m_vy = 1; m_se = 0; m_sd = 0;
      m_est = 0; m_cnt = 0; m_sdly = 0; m_pe = 0; m_pd = 0;
      return;
    end
    xe = int'(x_barra_esq); ye = int'(y_barra_esq); xd = int'(x_barra_dir); yd = int'(y_barra_dir);
    tk = (m_cnt == TD - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    m_pe = 0; m_pd = 0;
    if (m_est == 0 && saque) begin
      m_est = 1; m_cnt = 0; m_sdly = 0;
    end else if (m_est == 1 && tk) begin
      m_sdly++;
      if (m_sdly == SD) begin m_est = 2; m_cnt = 0; end
    end else if (m_est == 2 && tk) begin
      mag = m_vx < 0 ? -m_vx : m_vx;
      hl = m_vx < 0 && m_x <= xe + 20 && m_x + 10 >= xe && m_y + 10 > ye && m_y < ye + 60;
      hr = m_vx > 0 && m_x + 10 >= xd && m_x <= xd + 20 && m_y + 10 > yd && m_y < yd + 60;
      gd = !hl && m_vx < 0 && m_x < mag;
      ge = !hr && m_vx > 0 && m_x + 10 + mag > 640;
      if (hl) m_vx = porradao_esq ? 2 : 1;
      if (hr) m_vx = porradao_dir ? -2 : -1;
      if (ge || gd) begin
        if (ge) begin m_se++; m_pe = 1; m_vx = 1; end
        else begin m_sd++; m_pd = 1; m_vx = -1; end
        m_x = 315; m_y = 235;
        m_est = (m_se == 9 || m_sd == 9) ? 3 : 0;
      end else begin
        if (m_vy < 0 && m_y <= 1) m_vy = 1;
        else if (m_vy > 0 && m_y + 11 >= 480) m_vy = -1;
        m_y += m_vy;
        m_x += m_vx;
        if (m_x < 0) m_x = 0;
        if (m_x > 630) m_x = 630;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("cyc", {x_bola, y_bola, ponto_esq, ponto_dir, placar_esq, placar_dir, estado},
          {10'(m_x), 10'(m_y), m_pe, m_pd, 4'(m_se), 4'(m_sd), 2'(m_est)});
  endtask
  task automatic rand_inputs(input bit track);
    int t;
    saque = ($urandom_range(0, 3) == 0);
    porradao_esq = 1'($urandom_range(0, 1));
    porradao_dir = 1'($urandom_range(0, 1));
    x_barra_esq = 10'($urandom_range(0, 40));
    x_barra_dir = 10'($urandom_range(580, 620));
    t = m_y - int'($urandom_range(0, 55));
    y_barra_esq = (track && $urandom_range(0, 4) != 0) ? 10'(t < 0 ? 0 : t) : 10'd1000;
    t = m_y - int'($urandom_range(0, 55));
    y_barra_dir = (track && $urandom_range(0, 4) != 0) ? 10'(t < 0 ? 0 : t) : 10'd1000;
  endtask
  initial begin
    int n;
    repeat (3) cyc();
    check("rst_x", 32'(x_bola), 32'd315);
    check("rst_y", 32'(y_bola), 32'd235);
    check("rst_est", 32'(estado), 32'd0);
    reset = 1'b0;
    cyc();
    saque = 1'b1;
    cyc();
    saque = 1'b0;
    check("saque_est", 32'(estado), 32'd1);
    n = 0;
    while (estado != 2'd2 && n < 50) begin cyc(); n++; end
    check("saque_len", 32'(n), 32'd8);
    repeat (4) cyc();
    check("first_move", {22'd0, x_bola}, 32'd316);
    repeat (4) cyc();
    check("second_move", {22'd0, x_bola}, 32'd317);
    for (int i = 0; i < 20000 && m_est != 3; i++) begin
      cyc();
      rand_inputs(1'b1);
    end
    y_barra_esq = 10'd1000;
    y_barra_dir = 10'd1000;
    saque = 1'b1;
    for (int i = 0; i < 60000 && m_est != 3; i++) cyc();
    check("fim_reached", 32'(estado), 32'd3);
    repeat (20) cyc();
    check("fim_hold", 32'(estado), 32'd3);
    check("fim_nine", 32'(placar_esq == 4'd9 || placar_dir == 4'd9), 32'd1);
    check("fim_ball", {x_bola, y_bola}, {10'd315, 10'd235});
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_after_fim", {x_bola, y_bola, placar_esq, placar_dir, estado},
          {10'd315, 10'd235, 4'd0, 4'd0, 2'd0});
    saque = 1'b1;
    cyc();
    saque = 1'b0;
    repeat (40) cyc();
    check("mid_play", 32'(estado), 32'd2);
    reset = 1'b1;
    cyc();
    check("mid_rst", {x_bola, y_bola, ponto_esq, ponto_dir, placar_esq, placar_dir, estado},
          {10'd315, 10'd235, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0});
    reset = 1'b0;
    repeat (10) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
